// File: rtl/fifo_wr_stream_if.sv
// Write-side stream and FIFO-control bundle for fifo_wr_stream.
// The slave view is the write front end; the master view drives the
// producer stream plus the pointer-stage status signals.
interface fifo_wr_stream_if #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 4
);
  logic                s_valid;
  logic [DSIZE-1:0]    s_data;
  logic                s_ready;
  logic                winc;
  logic [DSIZE-1:0]    wdata;
  logic                wfull;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wlevel;

  modport slave (
    input  s_valid, s_data, wfull, wptr, wq2_rptr,
    output s_ready, winc, wdata, wlevel
  );

  modport master (
    output s_valid, s_data, wfull, wptr, wq2_rptr,
    input  s_ready, winc, wdata, wlevel
  );
endinterface

// File: rtl/fifo_wr_stream.sv
// Write-side front end of the async FIFO: two-entry skid buffer that keeps
// s_ready registered, write strobe gated by the registered full flag, and a
// registered occupancy estimate from the Gray write/read pointers.
module fifo_wr_stream #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  fifo_wr_stream_if.slave       bus
);

  logic [1:0]          count_q, count_d;
  logic [DSIZE-1:0]    slot0_q, slot0_d;
  logic [DSIZE-1:0]    slot1_q, slot1_d;
  logic                s_ready_q, s_ready_d;
  logic [ADDRSIZE:0]   wlevel_q, wlevel_d;

  logic                push;
  logic                pop;
  logic [1:0]          count_after_pop;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Skid buffer next state: apply the pop first, then land any push in the lowest free slot.
  always_comb begin
    pop             = (count_q != 2'd0) && !bus.wfull;
    push            = bus.s_valid && s_ready_q;
    slot0_d         = slot0_q;
    slot1_d         = slot1_q;
    count_after_pop = count_q - {1'b0, pop};
    if (pop && (count_q == 2'd2)) begin
      slot0_d = slot1_q;
    end
    if (push) begin
      if (count_after_pop == 2'd0) begin
        slot0_d = bus.s_data;
      end else begin
        slot1_d = bus.s_data;
      end
    end
    count_d   = count_after_pop + {1'b0, push};
    s_ready_d = (count_d < 2'd2);
  end

  // Occupancy estimate: binary difference of the decoded Gray pointers, wrapping naturally.
  always_comb begin
    wlevel_d = gray2bin(bus.wptr) - gray2bin(bus.wq2_rptr);
  end

  // State registers; reset discards buffered words and holds off the producer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      count_q   <= 2'd0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      s_ready_q <= 1'b0;
      wlevel_q  <= '0;
    end else begin
      count_q   <= count_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      s_ready_q <= s_ready_d;
      wlevel_q  <= wlevel_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.winc    = pop;
  assign bus.wdata   = slot0_q;
  assign bus.wlevel  = wlevel_q;

endmodule

// File: tb/tb_fifo_wr_stream.sv
// Testbench for fifo_wr_stream: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference of the skid buffer and
// an arithmetic reference of the pointer-difference level.
module tb_fifo_wr_stream;

  localparam int DSIZE    = 8;
  localparam int ADDRSIZE = 4;

  logic wclk = 1'b0;
  logic wrst_n;

  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0]  model_q[$];
  logic              m_ready;
  logic [ADDRSIZE:0] m_level;

  fifo_wr_stream_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) bus();

  fifo_wr_stream #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  // Free-running write clock, 10 time units per period.
  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  // Drive one cycle's inputs, compare outputs with the reference, then advance the reference.
  task automatic cycleBody(input logic v, input logic [DSIZE-1:0] d, input logic f,
                           input logic [ADDRSIZE:0] wb, input logic [ADDRSIZE:0] rb,
                           output logic acc);
    logic exp_winc;
    bus.s_valid  = v;
    bus.s_data   = d;
    bus.wfull    = f;
    bus.wptr     = bin2gray(wb);
    bus.wq2_rptr = bin2gray(rb);
    #1;
    exp_winc = (model_q.size() != 0) && !f;
    checkOutput("s_ready", 32'(bus.s_ready), 32'(m_ready));
    checkOutput("winc", 32'(bus.winc), 32'(exp_winc));
    if (exp_winc) checkOutput("wdata", 32'(bus.wdata), 32'(model_q[0]));
    checkOutput("wlevel", 32'(bus.wlevel), 32'(m_level));
    acc = v && m_ready;
    if (exp_winc) void'(model_q.pop_front());
    if (acc) model_q.push_back(d);
    m_ready = (model_q.size() < 2);
    m_level = wb - rb;
  endtask

  task automatic applyStimulus(input logic v, input logic [DSIZE-1:0] d, input logic f,
                               input logic [ADDRSIZE:0] wb, input logic [ADDRSIZE:0] rb,
                               output logic acc);
    @(negedge wclk);
    cycleBody(v, d, f, wb, rb, acc);
  endtask

  task automatic resetDut(input logic f);
    logic acc;
    @(negedge wclk);
    wrst_n      = 1'b0;
    bus.s_valid = 1'b1;
    bus.wfull   = f;
    #1;
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("rst_winc", 32'(bus.winc), 32'd0);
    checkOutput("rst_wlevel", 32'(bus.wlevel), 32'd0);
    model_q.delete();
    m_ready = 1'b0;
    m_level = '0;
    repeat (2) @(negedge wclk);
    checkOutput("rst_hold_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;
    cycleBody(1'b1, 8'hEE, 1'b0, 5'd3, 5'd1, acc);
  endtask

  // Main sequence: reset, directed scenarios, random traffic, mid-operation reset.
  initial begin
    logic             acc;
    logic [DSIZE-1:0] bp[3];
    int               idx;
    wrst_n       = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = '0;
    bus.wfull    = 1'b0;
    bus.wptr     = '0;
    bus.wq2_rptr = '0;
    model_q.delete();
    m_ready = 1'b0;
    m_level = '0;

    resetDut(1'b0);

    // Single beat.
    applyStimulus(1'b1, 8'hA5, 1'b0, 5'd0, 5'd0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, acc);

    // Backpressure: full flag held while the producer offers three words in order.
    bp[0] = 8'h01; bp[1] = 8'h02; bp[2] = 8'h03;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(idx < 3, bp[idx < 3 ? idx : 2], 1'b1, 5'd0, 5'd0, acc);
      if (acc) idx++;
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(idx < 3, bp[idx < 3 ? idx : 2], 1'b0, 5'd0, 5'd0, acc);
      if (acc) idx++;
    end

    // Streaming at full rate.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i * 7 + 3), 1'b0, 5'd0, 5'd0, acc);
    end
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, acc);

    // Level: plain case then wrap case.
    applyStimulus(1'b0, 8'h00, 1'b0, 5'd8, 5'd2, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 5'd1, 5'd31, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 5'd1, 5'd31, acc);

    // Randomized traffic with intermittent full flag and random pointers.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 9) < 3), 5'($urandom), 5'($urandom), acc);
    end

    // Mid-operation reset with a full buffer held off by wfull.
    repeat (3) applyStimulus(1'b1, 8'hC1, 1'b1, 5'd4, 5'd0, acc);
    resetDut(1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 5'd3, 5'd1, acc);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 9) < 2), 5'($urandom), 5'($urandom), acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_stream.md
# fifo_wr_stream

Write-side front end of the asynchronous FIFO, in the wclk domain directly upstream of the write-pointer/full-flag stage. It accepts a valid/ready stream from the producer and buffers up to two words in a skid buffer so that s_ready can be a register. It drives the write strobe and data toward the FIFO memory and pointer logic, and honours the registered full flag. It also reports a registered write-side occupancy estimate derived from the Gray-coded write pointer and the synchronized read pointer.

## Interface
- DSIZE, 8, data width in bits
- ADDRSIZE, 4, FIFO address width; depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits
- wclk  in  1  write clock; all logic is rising-edge
- wrst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  producer has a word on s_data
- s_data  in  DSIZE  producer data
- s_ready  out  1  registered; block accepts s_data this cycle
- winc  out  1  write strobe to the pointer stage and memory
- wdata  out  DSIZE  data written when winc=1; head of the skid buffer
- wfull  in  1  registered full flag from the pointer stage
- wptr  in  ADDRSIZE+1  Gray write pointer from the pointer stage
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, synchronized into wclk
- wlevel  out  ADDRSIZE+1  registered occupancy estimate, 0..2^ADDRSIZE

## Operation
- The skid buffer holds 2 entries, slot0 = head. count is in 0..2 and is the block's only state; there is no other FSM.
- push = s_valid & s_ready. pop = winc = (count != 0) & ~wfull. winc is combinational from registered state and wfull.
- wdata = slot0 whenever count != 0. When count == 0, wdata holds its last value and is don't-care.
- count_next = count + push - pop.
- Data movement:
  - On pop with count 2, slot1 moves to slot0.
  - A pushed word goes to the lowest free slot after the pop is applied.
  - push and pop in the same cycle at count 1: slot0 <= s_data, and count stays 1.
- s_ready <= (count_next < 2). It is therefore 0 in any cycle where count == 2, and no push can occur at count 2.
- Word order is strictly preserved. There is no drop and no duplication.
- wfull=1 freezes pops. The buffer absorbs at most 2 further words, then s_ready falls.
- Level calculation:
  - wbin = gray2bin(wptr) and rbin = gray2bin(wq2_rptr), both ADDRSIZE+1 bits.
  - wlevel <= (wbin - rbin) mod 2^(ADDRSIZE+1).
  - The result is conservative: rptr is stale, so wlevel can overestimate but never underestimate.
  - It does not include words still in the skid buffer.
- Reset (asynchronous, any time, including mid-transfer): count=0, slots cleared to 0, s_ready=0, wlevel=0. Buffered words are discarded.

## Timing
- s_ready rises on the first wclk edge after wrst_n deasserts.
- Latency from s_valid to winc is 1 cycle minimum: a word pushed at edge N has winc=1 in cycle N+1 if wfull=0.
- Sustained throughput is 1 word/cycle while wfull=0.
- After wfull asserts: s_ready drops at most 2 accepted words later. After wfull deasserts: winc=1 in the same cycle, and s_ready=1 again the cycle after the first pop.
- wlevel is updated 1 cycle after a change on wptr or wq2_rptr.
- wfull is driven by the pointer stage from the current-cycle winc, so winc & ~wfull never overfills the FIFO.

## Test plan
- Reset: hold wrst_n=0 with s_valid=1 -> s_ready=0, winc=0, wlevel=0. First edge after release -> s_ready=1.
- Single beat: s_data=0xA5 accepted at edge N, wfull=0 -> cycle N+1 has winc=1 and wdata=0xA5. Cycle N+2 has winc=0.
- Backpressure: wfull=1, stream 0x01,0x02,0x03 -> 0x01 and 0x02 accepted, s_ready=0, 0x03 held. Drop wfull -> winc writes 0x01, 0x02, 0x03 in consecutive cycles, in order.
- Streaming: s_valid=1 for 16 cycles with wfull=0 -> 16 consecutive winc pulses with matching data and no bubbles after the first.
- Level: wptr=5'b01100 (8) and wq2_rptr=5'b00011 (2) -> wlevel=6. Wrap case: wptr=5'b00001 (1) and wq2_rptr=5'b10000 (31) -> wlevel=2.
- Mid-operation reset: count=2 with wfull=1, assert wrst_n=0 -> s_ready=0 and winc=0 immediately. After release, no stale word is written.
